iobuf_halfduplex_ctrl: RTL and testbench
========================================

// Module: iobuf_halfduplex_ctrl
// PURPOSE
//  Sequencer for one bidirectional pad built from a tri-state IO buffer (I, T, O).
//  Serialises a WIDTH-bit word out of the pad, or releases the pad and deserialises a word in.
//  Guarantees a released-pad turnaround gap around every direction change, so two drivers never fight.
//  Sits between core request logic and the pad cell; drives the cell's I and T, reads its O.
// PARAMETERS
//  WIDTH  8  bits per transfer, MSB first; WIDTH >= 1
//  TURN   2  turnaround cycles with pad released (T=1); TURN >= 1
// PORTS
//  C          in   1      clock; all state updates on rising edge
//  CLR_N      in   1      asynchronous reset, active low
//  REQ_VALID  in   1      request present
//  REQ_WRITE  in   1      1 = drive word onto pad; 0 = read word from pad
//  REQ_DATA   in   WIDTH  word to drive; ignored for reads
//  REQ_READY  out  1      controller idle; request accepted on REQ_VALID & REQ_READY at a rising edge
//  RSP_VALID  out  1      one-cycle pulse: RSP_DATA holds the completed read word
//  RSP_DATA   out  WIDTH  last read word; holds until the next read completes
//  BUSY       out  1      ~REQ_READY
//  PAD_I      out  1      to buffer I: serial data while driving
//  PAD_T      out  1      to buffer T: 0 = drive pad, 1 = high-Z
//  PAD_O      in   1      from buffer O: pad level
// BEHAVIOUR
//  Clock C, asynchronous active-low reset CLR_N; no other clock or reset.
//  Reset (async, also mid-transfer): state IDLE, PAD_T=1 immediately, PAD_I=0, REQ_READY=1,
//   RSP_VALID=0, RSP_DATA=0, counters and shift register cleared; a partial transfer is dropped without response.
//  All outputs registered or decoded from the state register only; no combinational path from PAD_O or REQ_* to outputs.
//  States: IDLE, DRIVE, REL (post-write release), TURN (pre-read release), SAMPLE.
//  IDLE: PAD_T=1, REQ_READY=1. Accept write -> load shift=REQ_DATA, cnt=WIDTH-1, go DRIVE.
//   Accept read -> cnt=TURN-1, go TURN. REQ_VALID with REQ_READY=0 is ignored (requester must hold).
//  DRIVE: PAD_T=0, PAD_I=shift[WIDTH-1]; shift left each cycle; at cnt=0 load cnt=TURN-1, go REL.
//  REL: PAD_T=1 for exactly TURN cycles, then IDLE.
//  TURN: PAD_T=1 for exactly TURN cycles, then SAMPLE with cnt=WIDTH-1.
//  SAMPLE: PAD_T=1; each rising edge shifts PAD_O into LSB; at cnt=0 copy shift (with final bit) to RSP_DATA,
//   assert RSP_VALID for the following cycle, go IDLE.
//  Timing, request accepted at edge k: write drives bit WIDTH-1-i in cycle k+1+i, pad released from
//   cycle k+WIDTH+1, REQ_READY high again in cycle k+WIDTH+TURN+1. Read: pad released cycles k+1..k+TURN,
//   bit sampled at edges k+TURN+1 .. k+TURN+WIDTH, RSP_VALID high in cycle k+TURN+WIDTH+1.
//  RSP_VALID and REQ_READY are both high in the completion cycle; a request accepted then is legal
//   (back-to-back reads keep the pad released; a write after a read starts driving the next cycle).
//  PAD_T is 0 only in DRIVE; every DRIVE is followed by TURN released cycles before any next drive.
//  cnt width = $clog2(max(WIDTH,TURN)); down-counter, no wrap beyond 0 within a state.
//  PAD_I is 0 whenever PAD_T=1.
// STRUCTURE
//  Shared defines file iobuf_hd_defs.vh: state encodings (IDLE=0, DRIVE=1, REL=2, TURN=3, SAMPLE=4),
//   state register width, default WIDTH/TURN.
//  One sub-module: iobuf_hd_shreg (WIDTH-bit load/shift-left register, serial in at LSB, serial out at MSB),
//   shared by DRIVE and SAMPLE. FSM and counter live in the top module.
//  Top level instantiates nothing else; the tri-state buffer itself is instantiated by the user.
// TESTING (bench models pad as buffer + remote driver that asserts contention on any overlap)
//  Write 8'hA5, WIDTH=8, TURN=2 -> PAD_T=0 for 8 cycles, PAD_I = 1,0,1,0,0,1,0,1; then 2 cycles T=1; REQ_READY back.
//  Read, remote drives 8'h3C starting after 2 released cycles -> RSP_VALID one cycle, RSP_DATA=8'h3C, no contention.
//  Write 8'hFF then read immediately at completion edge -> at least TURN released cycles between drivers; read returns remote word.
//  Back-to-back reads 8'h01, 8'h80 with REQ_VALID held high -> two RSP_VALID pulses exactly WIDTH+TURN+1 cycles apart.
//  CLR_N low mid-DRIVE (bit 3 of 8) -> PAD_T=1 asynchronously, no RSP_VALID, REQ_READY=1 after release; next write correct.
//  REQ_VALID while BUSY -> ignored; REQ_DATA changes during transfer do not alter driven bits.

Source files
------------

// File: rtl/iobuf_halfduplex_ctrl_pkg.sv
// Shared definitions for the half-duplex pad sequencer: state encodings,
// default geometry and the counter-width helper.
package iobuf_halfduplex_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_TURN  = 2;
  localparam int STATE_W       = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_REL    = 3'd2,
    ST_TURN   = 3'd3,
    ST_SAMPLE = 3'd4
  } state_e;

  // One counter serves both word and turnaround phases, so size it for the larger.
  function automatic int cnt_width(input int width, input int turn);
    int m;
    m = (width > turn) ? width : turn;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/iobuf_hd_shreg.sv
// Load / shift-left register: serial in at the LSB, serial out at the MSB.
// Shared by the drive (serialise) and sample (deserialise) phases.
module iobuf_hd_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_shifted,
  output logic             serial_out
);

  generate
    if (WIDTH == 1) begin : g_one
      assign q_shifted = serial_in;
    end else begin : g_multi
      assign q_shifted = {q[WIDTH-2:0], serial_in};
    end
  endgenerate

  // NOTE: this is a plain register, not a memory array, so it takes the async
  // reset like any other state; that keeps PAD_I defined straight out of reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift) begin
      q <= q_shifted;
    end
  end

  assign serial_out = q[WIDTH-1];

endmodule

// File: rtl/iobuf_halfduplex_ctrl.sv
// Half-duplex sequencer for one tri-state pad: serialises writes MSB first,
// deserialises reads, and inserts a released-pad gap around direction changes.
module iobuf_halfduplex_ctrl
  import iobuf_halfduplex_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int TURN  = DEFAULT_TURN
) (
  input  logic             C,
  input  logic             CLR_N,
  input  logic             REQ_VALID,
  input  logic             REQ_WRITE,
  input  logic [WIDTH-1:0] REQ_DATA,
  output logic             REQ_READY,
  output logic             RSP_VALID,
  output logic [WIDTH-1:0] RSP_DATA,
  output logic             BUSY,
  output logic             PAD_I,
  output logic             PAD_T,
  input  logic             PAD_O
);

  localparam int               CNT_W    = cnt_width(WIDTH, TURN);
  localparam logic [CNT_W-1:0] CNT_WORD = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_TURN = CNT_W'(TURN - 1);

  state_e           state;
  state_e           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             accept;
  logic             sh_load;
  logic             sh_shift;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] sh_next;
  logic             sh_msb;

  assign cnt_zero = (cnt == '0);
  assign accept   = REQ_VALID && (state == ST_IDLE);
  assign sh_load  = accept && REQ_WRITE;
  assign sh_shift = (state == ST_DRIVE) || (state == ST_SAMPLE);

  // Bits shifted in while driving are the pad echo; they are flushed by the
  // time the next word is loaded or fully sampled.
  iobuf_hd_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk        (C),
    .rst_n      (CLR_N),
    .load       (sh_load),
    .shift      (sh_shift),
    .serial_in  (PAD_O),
    .load_data  (REQ_DATA),
    .q          (sh_q),
    .q_shifted  (sh_next),
    .serial_out (sh_msb)
  );

  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (REQ_VALID) state_nxt = REQ_WRITE ? ST_DRIVE : ST_TURN;
      ST_DRIVE:  if (cnt_zero)  state_nxt = ST_REL;
      ST_REL:    if (cnt_zero)  state_nxt = ST_IDLE;
      ST_TURN:   if (cnt_zero)  state_nxt = ST_SAMPLE;
      ST_SAMPLE: if (cnt_zero)  state_nxt = ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    PAD_T     = 1'b1;
    PAD_I     = 1'b0;
    REQ_READY = 1'b0;
    unique case (state)
      ST_IDLE:  REQ_READY = 1'b1;
      ST_DRIVE: begin
        PAD_T = 1'b0;
        PAD_I = sh_msb;
      end
      default: ;
    endcase
  end

  assign BUSY = ~REQ_READY;

  // Phase counter plus read completion; the final pad bit is captured
  // through the shifter's next-value so the response is ready on the same edge.
  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      cnt       <= '0;
      RSP_VALID <= 1'b0;
      RSP_DATA  <= '0;
    end else begin
      RSP_VALID <= 1'b0;
      unique case (state)
        ST_IDLE:   if (accept) cnt <= REQ_WRITE ? CNT_WORD : CNT_TURN;
        ST_DRIVE:  cnt <= cnt_zero ? CNT_TURN : cnt - 1'b1;
        ST_REL:    if (!cnt_zero) cnt <= cnt - 1'b1;
        ST_TURN:   cnt <= cnt_zero ? CNT_WORD : cnt - 1'b1;
        ST_SAMPLE: begin
          if (cnt_zero) begin
            RSP_VALID <= 1'b1;
            RSP_DATA  <= sh_next;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_iobuf_halfduplex_ctrl.sv
// Bench for iobuf_halfduplex_ctrl: pad modelled as buffer plus remote driver,
// expectations derived from the transfer timing rules.
module tb_iobuf_halfduplex_ctrl;

  localparam int W = 8;
  localparam int T = 2;

  logic         C = 1'b0;
  logic         CLR_N;
  logic         REQ_VALID;
  logic         REQ_WRITE;
  logic [W-1:0] REQ_DATA;
  logic         REQ_READY;
  logic         RSP_VALID;
  logic [W-1:0] RSP_DATA;
  logic         BUSY;
  logic         PAD_I;
  logic         PAD_T;
  logic         PAD_O;

  logic         remote_en  = 1'b0;
  logic         remote_bit = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int contention = 0;
  int min_gap    = 1000;
  int last_dut   = 0;
  bit have_dut   = 1'b0;

  logic [W-1:0] model_rsp;

  iobuf_halfduplex_ctrl #(.WIDTH(W), .TURN(T)) dut (
    .C         (C),
    .CLR_N     (CLR_N),
    .REQ_VALID (REQ_VALID),
    .REQ_WRITE (REQ_WRITE),
    .REQ_DATA  (REQ_DATA),
    .REQ_READY (REQ_READY),
    .RSP_VALID (RSP_VALID),
    .RSP_DATA  (RSP_DATA),
    .BUSY      (BUSY),
    .PAD_I     (PAD_I),
    .PAD_T     (PAD_T),
    .PAD_O     (PAD_O)
  );

  always #5 C = ~C;

  // Pad: DUT wins when it drives, else the remote, else a weak pull-down.
  assign PAD_O = !PAD_T ? PAD_I : (remote_en ? remote_bit : 1'b0);

  always @(posedge C) cyc <= cyc + 1;

  always @(negedge C) begin
    if (!PAD_T && remote_en) contention++;
    if (remote_en && have_dut && (cyc - last_dut - 1) < min_gap) min_gap = cyc - last_dut - 1;
    if (!PAD_T) begin
      last_dut = cyc;
      have_dut = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge C);
    #1;
  endtask

  task automatic busy_noise;
    REQ_VALID = 1'($urandom_range(1, 0));
    REQ_WRITE = 1'($urandom_range(1, 0));
    REQ_DATA  = W'($urandom);
  endtask

  task automatic idle(input int n);
    REQ_VALID = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      check("idle_ready", REQ_READY, 1);
      check("idle_rsp_valid", RSP_VALID, 0);
      check("idle_pad_t", PAD_T, 1);
    end
  endtask

  // Starts in a cycle where the controller is idle; ends in the completion cycle.
  task automatic do_write(input logic [W-1:0] d);
    check("wr_ready", REQ_READY, 1);
    REQ_VALID = 1'b1;
    REQ_WRITE = 1'b1;
    REQ_DATA  = d;
    tick();
    for (int i = 0; i < W; i++) begin
      busy_noise();
      check("wr_pad_t", PAD_T, 0);
      check("wr_pad_i", PAD_I, d[W-1-i]);
      check("wr_busy", BUSY, 1);
      check("wr_rsp_valid", RSP_VALID, 0);
      check("wr_rsp_data", RSP_DATA, model_rsp);
      tick();
    end
    for (int i = 0; i < T; i++) begin
      busy_noise();
      check("rel_pad_t", PAD_T, 1);
      check("rel_pad_i", PAD_I, 0);
      check("rel_ready", REQ_READY, 0);
      tick();
    end
    REQ_VALID = 1'b0;
    check("wr_done_ready", REQ_READY, 1);
    check("wr_done_busy", BUSY, 0);
    check("wr_done_rsp_valid", RSP_VALID, 0);
  endtask

  task automatic do_read(input logic [W-1:0] word);
    check("rd_ready", REQ_READY, 1);
    REQ_VALID = 1'b1;
    REQ_WRITE = 1'b0;
    REQ_DATA  = W'($urandom);
    tick();
    for (int i = 0; i < T; i++) begin
      busy_noise();
      check("rd_turn_pad_t", PAD_T, 1);
      check("rd_turn_pad_i", PAD_I, 0);
      check("rd_turn_busy", BUSY, 1);
      check("rd_turn_rsp_valid", RSP_VALID, 0);
      tick();
    end
    for (int i = 0; i < W; i++) begin
      busy_noise();
      remote_en  = 1'b1;
      remote_bit = word[W-1-i];
      check("rd_smp_pad_t", PAD_T, 1);
      check("rd_smp_busy", BUSY, 1);
      check("rd_smp_rsp_valid", RSP_VALID, 0);
      check("rd_smp_rsp_data", RSP_DATA, model_rsp);
      tick();
    end
    remote_en = 1'b0;
    REQ_VALID = 1'b0;
    model_rsp = word;
    check("rd_rsp_valid", RSP_VALID, 1);
    check("rd_rsp_data", RSP_DATA, model_rsp);
    check("rd_done_ready", REQ_READY, 1);
    check("rd_done_pad_t", PAD_T, 1);
  endtask

  initial begin
    int p0;
    int p1;
    logic [W-1:0] d;

    CLR_N     = 1'b0;
    REQ_VALID = 1'b0;
    REQ_WRITE = 1'b0;
    REQ_DATA  = '0;
    model_rsp = '0;
    #1;
    check("rst_pad_t", PAD_T, 1);
    check("rst_pad_i", PAD_I, 0);
    check("rst_ready", REQ_READY, 1);
    check("rst_busy", BUSY, 0);
    check("rst_rsp_valid", RSP_VALID, 0);
    check("rst_rsp_data", RSP_DATA, 0);
    #11;
    CLR_N = 1'b1;
    tick();
    idle(2);

    do_write(8'hA5);
    idle(1);
    do_read(8'h3C);
    idle(1);

    // Write then read accepted on the write's completion edge.
    do_write(8'hFF);
    do_read(8'h5A);

    // Back-to-back reads: second accepted on the first's completion edge.
    do_read(8'h01);
    p0 = cyc;
    do_read(8'h80);
    p1 = cyc;
    check("b2b_spacing", p1 - p0, W + T + 1);

    // Read followed directly by a write.
    do_write(8'h69);
    idle(1);

    // Reset while driving the fourth bit of a write.
    d = 8'hC3;
    REQ_VALID = 1'b1;
    REQ_WRITE = 1'b1;
    REQ_DATA  = d;
    tick();
    for (int i = 0; i < 3; i++) begin
      REQ_DATA = W'($urandom);
      REQ_VALID = 1'b0;
      check("pre_rst_pad_i", PAD_I, d[W-1-i]);
      tick();
    end
    check("pre_rst_pad_t", PAD_T, 0);
    #2;
    CLR_N = 1'b0;
    #1;
    model_rsp = '0;
    check("mid_rst_pad_t", PAD_T, 1);
    check("mid_rst_pad_i", PAD_I, 0);
    check("mid_rst_ready", REQ_READY, 1);
    check("mid_rst_rsp_valid", RSP_VALID, 0);
    check("mid_rst_rsp_data", RSP_DATA, model_rsp);
    tick();
    check("in_rst_pad_t", PAD_T, 1);
    #3;
    CLR_N = 1'b1;
    idle(2);
    do_write(8'h96);
    idle(1);

    for (int n = 0; n < 40; n++) begin
      d = W'($urandom);
      if ($urandom_range(1, 0) == 1) do_write(d);
      else do_read(d);
      idle($urandom_range(2, 0));
    end

    idle(2);
    check("no_contention", contention, 0);
    check("min_turn_gap_ok", (min_gap >= T) ? 1 : 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
